// File: rtl/se_qubip_arbiter.sv
// se_qubip_arbiter: round-robin two-requester scheduler for the secure-element core bus
// Ports: i_clk/i_rst clock and async reset; i_req/i_lock per-requester request and session lock;
// i_mod/i_ctrl/i_add/i_data per-requester payloads; o_gnt one-hot grant; o_done/o_err beat
// completion and timeout pulses; o_dout captured core data; o_busy not idle; o_se_* core bus;
// i_se_data/i_se_end_op core response.
module se_qubip_arbiter #(
  parameter int SETTLE_CYC = 2,
  parameter int TO_W = 20
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_req,
  input  logic [1:0]   i_lock,
  input  logic [63:0]  i_mod,
  input  logic [63:0]  i_ctrl,
  input  logic [127:0] i_add,
  input  logic [127:0] i_data,
  output logic [1:0]   o_gnt,
  output logic [1:0]   o_done,
  output logic [1:0]   o_err,
  output logic [63:0]  o_dout,
  output logic         o_busy,
  output logic [63:0]  o_se_control,
  output logic [63:0]  o_se_add,
  output logic [63:0]  o_se_data,
  input  logic [63:0]  i_se_data,
  input  logic         i_se_end_op
);
  typedef enum logic [2:0] {IDLE, ARB, DRIVE, WAIT, RESP, HOLD, TOUT} state_t;
  state_t state;
  logic g, last, win;
  logic [1:0] sel;
  logic [3:0] scnt;
  logic [TO_W-1:0] tcnt;
  logic [63:0] ctl_sel, add_sel, dat_sel;
  // both requesting: the one not served last; otherwise whichever is asking
  assign win = (i_req == 2'b11) ? ~last : i_req[1];
  assign sel = g ? 2'b10 : 2'b01;
  assign ctl_sel = g ? {i_mod[63:32], i_ctrl[63:32]} : {i_mod[31:0], i_ctrl[31:0]};
  assign add_sel = g ? i_add[127:64] : i_add[63:0];
  assign dat_sel = g ? i_data[127:64] : i_data[63:0];
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      g <= 1'b0;
      last <= 1'b1;
      scnt <= '0;
      tcnt <= '0;
      o_gnt <= '0;
      o_done <= '0;
      o_err <= '0;
      o_dout <= '0;
      o_se_control <= '0;
      o_se_add <= '0;
      o_se_data <= '0;
    end else begin
      o_done <= '0;
      o_err <= '0;
      case (state)
        IDLE: if (|i_req) begin
          g <= win;
          last <= win;
          o_gnt <= win ? 2'b10 : 2'b01;
          state <= ARB;
        end
        ARB: begin
          scnt <= '0;
          tcnt <= '0;
          o_se_control <= ctl_sel;
          o_se_add <= add_sel;
          o_se_data <= dat_sel;
          state <= DRIVE;
        end
        DRIVE: begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'(SETTLE_CYC - 1)) state <= WAIT;
        end
        // timeout fires on the cycle the counter would reach all-ones; end_op has priority
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (i_se_end_op) begin
            o_done <= sel;
            o_dout <= i_se_data;
            state <= RESP;
          end else if (tcnt == {{(TO_W-1){1'b1}}, 1'b0}) begin
            o_done <= sel;
            o_err <= sel;
            o_dout <= '1;
            o_se_control <= '0;
            state <= TOUT;
          end
        end
        RESP: if (i_lock[g]) state <= HOLD;
        else begin
          o_gnt <= '0;
          o_se_control <= '0;
          state <= IDLE;
        end
        // module stays selected; a new beat from the owner skips arbitration
        HOLD: if (i_req[g]) begin
          scnt <= '0;
          tcnt <= '0;
          o_se_control <= ctl_sel;
          o_se_add <= add_sel;
          o_se_data <= dat_sel;
          state <= DRIVE;
        end else if (!i_lock[g]) begin
          o_gnt <= '0;
          o_se_control <= '0;
          state <= IDLE;
        end
        TOUT: begin
          o_gnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_se_qubip_arbiter.sv
// tb_se_qubip_arbiter: randomized self-checking bench with a beat-level reference model
module tb_se_qubip_arbiter;
  localparam int S = 2;
  localparam int TW = 4;
  localparam int TMO = (1 << TW) - 1;
  logic i_clk = 1'b0;
  logic i_rst;
  logic [1:0] i_req, i_lock;
  logic [63:0] i_mod, i_ctrl;
  logic [127:0] i_add, i_data;
  logic [63:0] i_se_data;
  logic i_se_end_op;
  logic [1:0] o_gnt, o_done, o_err;
  logic [63:0] o_dout, o_se_control, o_se_add, o_se_data;
  logic o_busy;
  logic [31:0] mod_v [2];
  logic [31:0] ctl_v [2];
  logic [63:0] add_v [2];
  logic [63:0] dat_v [2];
  logic last, g_m;
  bit held;
  int n_chk = 0;
  int n_fail = 0;
  assign i_mod = {mod_v[1], mod_v[0]};
  assign i_ctrl = {ctl_v[1], ctl_v[0]};
  assign i_add = {add_v[1], add_v[0]};
  assign i_data = {dat_v[1], dat_v[0]};
  se_qubip_arbiter #(.SETTLE_CYC(S), .TO_W(TW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_lock(i_lock),
    .i_mod(i_mod), .i_ctrl(i_ctrl), .i_add(i_add), .i_data(i_data),
    .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err), .o_dout(o_dout), .o_busy(o_busy),
    .o_se_control(o_se_control), .o_se_add(o_se_add), .o_se_data(o_se_data),
    .i_se_data(i_se_data), .i_se_end_op(i_se_end_op)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
    chk("gnt_onehot", 64'($countones(o_gnt) < 2), 64'd1);
  endtask
  function automatic logic [1:0] oh(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction
  task automatic new_payload();
    for (int i = 0; i < 2; i++) begin
      mod_v[i] = 32'($urandom_range(2, 8)) << 4;
      ctl_v[i] = $urandom;
      add_v[i] = {$urandom, $urandom};
      dat_v[i] = {$urandom, $urandom};
    end
  endtask
  // k = WAIT cycles until end_op (0 = core never answers); stale = end_op held high all along
  task automatic beat(input logic [1:0] req, input logic [1:0] lock, input int k, input bit stale,
                      input bit from_hold, input bit wd, input logic [1:0] nreq);
    logic g;
    int lead, due;
    logic [63:0] exp_d, pay;
    bit to, seen, hold;
    g = from_hold ? g_m : (req == 2'b11 ? ~last : req[1]);
    if (!from_hold) last = g;
    g_m = g;
    to = (k == 0) && !stale;
    lead = from_hold ? 1 : 2;
    due = lead + S + (to ? TMO : (stale ? 1 : k));
    pay = {mod_v[g], ctl_v[g]};
    i_req = req;
    i_lock = lock;
    i_se_end_op = stale;
    i_se_data = {$urandom, $urandom};
    exp_d = '1;
    seen = 0;
    for (int c = 1; c <= due + 4 && !seen; c++) begin
      tick();
      if (o_done != 2'b00) begin
        seen = 1;
        chk("latency", 64'(c), 64'(due));
        chk("done", 64'(o_done), 64'(oh(g)));
        chk("err", 64'(o_err), to ? 64'(oh(g)) : 64'd0);
        chk("dout", o_dout, exp_d);
        chk("se_ctl_resp", o_se_control, to ? 64'd0 : pay);
        chk("gnt_resp", 64'(o_gnt), 64'(oh(g)));
      end else begin
        if (c == 1 && !from_hold) chk("gnt_arb", 64'(o_gnt), 64'(oh(g)));
        if (c == lead) begin
          chk("se_ctl", o_se_control, pay);
          chk("se_add", o_se_add, add_v[g]);
          chk("se_data", o_se_data, dat_v[g]);
          chk("busy", 64'(o_busy), 64'd1);
        end
        if (wd && c == lead) i_req = 2'b00;
        i_se_data = {$urandom, $urandom};
        i_se_end_op = stale || (!to && c == lead + S + k - 1);
        if (!to && c == due - 1) exp_d = i_se_data;
      end
    end
    if (!seen) chk("done_seen", 64'd0, 64'd1);
    hold = lock[g] && !to && seen;
    i_se_end_op = 1'b0;
    i_req = nreq;
    tick();
    chk("post_gnt", 64'(o_gnt), hold ? 64'(oh(g)) : 64'd0);
    chk("post_ctl", o_se_control, hold ? pay : 64'd0);
    chk("post_busy", 64'(o_busy), 64'(hold));
    held = hold;
  endtask
  task automatic release_hold(input logic [1:0] nreq);
    i_req = nreq;
    i_lock = 2'b00;
    tick();
    chk("rel_gnt", 64'(o_gnt), 64'd0);
    chk("rel_ctl", o_se_control, 64'd0);
    held = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 64'({o_gnt, o_done, o_err, o_busy}), 64'd0);
    chk({tag, "_dout"}, o_dout, 64'd0);
    chk({tag, "_ctl"}, o_se_control, 64'd0);
    chk({tag, "_bus"}, o_se_add | o_se_data, 64'd0);
  endtask
  initial begin
    logic [1:0] rq, lk;
    int r, k;
    i_rst = 1'b1;
    i_req = 2'b00;
    i_lock = 2'b00;
    i_se_end_op = 1'b0;
    i_se_data = '0;
    new_payload();
    last = 1'b1;
    g_m = 1'b0;
    held = 0;
    repeat (2) @(negedge i_clk);
    chk_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    new_payload();
    mod_v[0] = 32'h30;
    ctl_v[0] = 32'h1;
    beat(2'b01, 2'b00, 5, 0, 0, 0, 2'b00);
    new_payload();
    beat(2'b11, 2'b00, 3, 0, 0, 0, 2'b11);
    beat(2'b11, 2'b00, 2, 0, 0, 0, 2'b00);
    new_payload();
    beat(2'b10, 2'b10, 4, 0, 0, 0, 2'b11);
    beat(2'b11, 2'b10, 3, 0, 1, 0, 2'b11);
    beat(2'b11, 2'b10, 6, 0, 1, 0, 2'b01);
    tick();
    chk("hold_stays", 64'(o_gnt), 64'(2'b10));
    release_hold(2'b01);
    beat(2'b01, 2'b00, 2, 0, 0, 0, 2'b00);
    new_payload();
    beat(2'b01, 2'b00, 0, 1, 0, 0, 2'b00);
    beat(2'b10, 2'b00, 0, 0, 0, 0, 2'b00);
    beat(2'b01, 2'b01, 0, 0, 0, 0, 2'b00);
    beat(2'b01, 2'b00, TMO, 0, 0, 0, 2'b00);
    i_req = 2'b01;
    last = 1'b0;
    repeat (5) tick();
    #2 i_rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    i_req = 2'b00;
    last = 1'b1;
    tick();
    beat(2'b11, 2'b00, 2, 0, 0, 0, 2'b00);
    repeat (40) begin
      r = $urandom_range(0, 9);
      k = (r == 0) ? 0 : $urandom_range(1, 6);
      lk = 2'($urandom_range(0, 3));
      new_payload();
      if (held && $urandom_range(0, 1) == 1) begin
        rq = oh(g_m) | 2'($urandom_range(0, 3));
        beat(rq, lk, k, r == 1, 1, $urandom_range(0, 3) == 0, 2'b00);
      end else begin
        if (held) release_hold(2'b00);
        rq = 2'($urandom_range(1, 3));
        beat(rq, lk, k, r == 1, 0, $urandom_range(0, 3) == 0, 2'b00);
      end
    end
    if (held) release_hold(2'b00);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
